// File: rtl/gate_mux_exerciser.sv
// Self-test sequencer for the 5-switch gate-select/LED block: walks all 32 switch
// vectors, samples the synchronised LED after a settle interval and scores it.
module gate_mux_exerciser #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             led_in,
    output logic [4:0]       sw_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [4:0]       first_fail_vec
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [4:0]         vector_reg;
    logic [SETTLE_W-1:0] settle_reg;
    logic [4:0]         sw_out_reg;
    logic [ERR_W-1:0]   err_count_reg;
    logic [ERR_W-1:0]   err_count_next;
    logic               first_fail_valid_reg;
    logic [4:0]         first_fail_vec_reg;
    logic               led_meta_reg;
    logic               led_s_reg;

    logic [31:0]        expected_lut;
    logic               settle_last;
    logic               last_vector;
    logic               mismatch;

    // Gate function selected by sw[4:2] on inputs a=sw[0], b=sw[1].
    function automatic logic gate_model(input logic [4:0] vec);
        logic a;
        logic b;
        logic y;
        a = vec[0];
        b = vec[1];
        case (vec[4:2])
            3'd0:    y = ~(a & b);
            3'd1:    y = a & b;
            3'd2:    y = ~(a | b);
            3'd3:    y = a | b;
            3'd4:    y = a ^ b;
            3'd5:    y = ~(a ^ b);
            3'd6:    y = a;
            default: y = ~a;
        endcase
        return y;
    endfunction

    // Constant truth table over all 32 switch vectors.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_lut
            assign expected_lut[gi] = gate_model(5'(gi));
        end
    endgenerate

    assign settle_last = (settle_reg == SETTLE_W'(SETTLE_CYCLES - 1));
    assign last_vector = (vector_reg == 5'd31);
    assign mismatch    = (led_s_reg != expected_lut[sw_out_reg]);

    always_comb begin
        err_count_next = err_count_reg;
        if (mismatch && (err_count_reg != {ERR_W{1'b1}})) begin
            err_count_next = err_count_reg + ERR_W'(1);
        end
    end

    // led_in is asynchronous to clk; only the second flop is ever observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_meta_reg <= 1'b0;
            led_s_reg    <= 1'b0;
        end else begin
            led_meta_reg <= led_in;
            led_s_reg    <= led_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_DRIVE;
            ST_DRIVE: if (settle_last) state_next = ST_CHECK;
            ST_CHECK: state_next = last_vector ? ST_DONE : ST_DRIVE;
            ST_DONE:  if (start) state_next = ST_DRIVE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ST_DRIVE) || (state_reg == ST_CHECK);
        done = (state_reg == ST_DONE);
        pass = (state_reg == ST_DONE) && (err_count_reg == '0);
    end

    // sw_out only changes on run start and on leaving CHECK, so it is stable
    // for the whole DRIVE+CHECK window of each vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vector_reg           <= 5'd0;
            settle_reg           <= '0;
            sw_out_reg           <= 5'd0;
            err_count_reg        <= '0;
            first_fail_valid_reg <= 1'b0;
            first_fail_vec_reg   <= 5'd0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vector_reg           <= 5'd0;
                        settle_reg           <= '0;
                        sw_out_reg           <= 5'd0;
                        err_count_reg        <= '0;
                        first_fail_valid_reg <= 1'b0;
                        first_fail_vec_reg   <= 5'd0;
                    end
                end
                ST_DRIVE: begin
                    settle_reg <= settle_reg + SETTLE_W'(1);
                end
                ST_CHECK: begin
                    err_count_reg <= err_count_next;
                    if (mismatch && !first_fail_valid_reg) begin
                        first_fail_valid_reg <= 1'b1;
                        first_fail_vec_reg   <= sw_out_reg;
                    end
                    if (last_vector) begin
                        sw_out_reg <= 5'd0;
                    end else begin
                        vector_reg <= vector_reg + 5'd1;
                        sw_out_reg <= vector_reg + 5'd1;
                        settle_reg <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sw_out           = sw_out_reg;
    assign err_count        = err_count_reg;
    assign first_fail_valid = first_fail_valid_reg;
    assign first_fail_vec   = first_fail_vec_reg;

endmodule

// File: tb/tb_gate_mux_exerciser.sv
// Bench for gate_mux_exerciser: a selectable LED model closes the loop, a table
// of run scenarios plus hand-written reset/restart sequences score the results.
module tb_gate_mux_exerciser;

    localparam int SETTLE  = 4;
    localparam int ERR_W   = 6;
    localparam int RUN_LEN = 32 * (SETTLE + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             led_in;
    logic [4:0]       sw_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             first_fail_valid;
    logic [4:0]       first_fail_vec;

    gate_mux_exerciser #(
        .SETTLE_CYCLES(SETTLE),
        .ERR_W(ERR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .led_in(led_in),
        .sw_out(sw_out),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_fail_valid(first_fail_valid),
        .first_fail_vec(first_fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LED model: 0 golden, 1 stuck-0, 2 stuck-1, 3 xor/xnor swapped, 4 inverted
    int mode;

    function automatic logic bench_led(input int m, input logic [4:0] v);
        logic a;
        logic b;
        logic g;
        a = v[0];
        b = v[1];
        case (v[4:2])
            3'd0:    g = ~(a & b);
            3'd1:    g = a & b;
            3'd2:    g = ~(a | b);
            3'd3:    g = a | b;
            3'd4:    g = (m == 3) ? ~(a ^ b) : (a ^ b);
            3'd5:    g = (m == 3) ? (a ^ b) : ~(a ^ b);
            3'd6:    g = a;
            default: g = ~a;
        endcase
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            4:       return ~g;
            default: return g;
        endcase
    endfunction

    always_comb led_in = bench_led(mode, sw_out);

    typedef struct {
        int mode;
        int pulse_at;
        int exp_err;
        int exp_ffv;
        int exp_ffvec;
        int exp_pass;
    } vec_t;

    typedef struct {
        int err;
        int ffv;
        int ffvec;
        int pass;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end else begin
            $display("ok   %s value=%0d", name, actual);
        end
    endtask

    task automatic push_exp(input int err, input int ffv, input int ffvec, input int p);
        exp_t e;
        e.err   = err;
        e.ffv   = ffv;
        e.ffvec = ffvec;
        e.pass  = p;
        sb_q.push_back(e);
    endtask

    // Called just after the edge that accepted start; follows the run to done.
    task automatic run_checked(input int pulse_at, input bit hold_start);
        int   cycles;
        int   bad_sw;
        bit   seen;
        exp_t e;
        cycles = 0;
        bad_sw = 0;
        seen   = 1'b0;
        while (cycles < RUN_LEN + 20) begin
            @(negedge clk);
            if (cycles == 0) begin
                check("done_clear", done, 0);
                check("busy_set", busy, 1);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (sw_out != 5'(cycles / (SETTLE + 1)) || !busy) bad_sw++;
            if (!hold_start) start = (cycles == pulse_at);
            cycles++;
        end
        check("done_seen", seen, 1);
        check("latency", cycles, RUN_LEN);
        check("sw_seq", bad_sw, 0);
        check("busy_at_done", busy, 0);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            $display("run mode=%0d err=%0d ffv=%0d ffvec=%0d pass=%0d",
                     mode, err_count, first_fail_valid, first_fail_vec, pass);
            check("err_count", err_count, e.err);
            check("ff_valid", first_fail_valid, e.ffv);
            check("ff_vec", first_fail_vec, e.ffvec);
            check("pass", pass, e.pass);
        end
    endtask

    task automatic run_one(input int pulse_at);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        run_checked(pulse_at, 1'b0);
    endtask

    vec_t tbl[7];

    initial begin
        int  waited;
        bit  reached;

        tbl[0] = '{0, -1,  0, 0,  0, 1};
        tbl[1] = '{1, -1, 16, 1,  0, 0};
        tbl[2] = '{2, -1, 16, 1,  3, 0};
        tbl[3] = '{3, -1,  8, 1, 16, 0};
        tbl[4] = '{4, -1, 32, 1,  0, 0};
        tbl[5] = '{0, 30,  0, 0,  0, 1};
        tbl[6] = '{0, -1,  0, 0,  0, 1};

        checks   = 0;
        failures = 0;
        mode     = 0;
        start    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_sw", sw_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_ffv", first_fail_valid, 0);
        check("rst_ffvec", first_fail_vec, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        for (int i = 0; i < 7; i++) begin
            mode = tbl[i].mode;
            push_exp(tbl[i].exp_err, tbl[i].exp_ffv, tbl[i].exp_ffvec, tbl[i].exp_pass);
            run_one(tbl[i].pulse_at);
        end

        // start held high: one run, then immediate restart from DONE
        mode = 0;
        push_exp(0, 0, 0, 1);
        push_exp(0, 0, 0, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        run_checked(-1, 1'b1);
        run_checked(-1, 1'b0);

        // asynchronous reset at vector 12
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waited  = 0;
        reached = 1'b0;
        while (waited < RUN_LEN) begin
            @(negedge clk);
            if (sw_out == 5'd12) begin
                reached = 1'b1;
                break;
            end
            waited++;
        end
        check("reach_vec12", reached, 1);
        check("err_before_rst", err_count != 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sw", sw_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err_count, 0);
        check("arst_ffv", first_fail_valid, 0);
        check("arst_ffvec", first_fail_vec, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        mode = 0;
        push_exp(0, 0, 0, 1);
        run_one(-1);

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_mux_exerciser.md
Name: gate_mux_exerciser

Overview:
- Self-test sequencer for the 5-switch gate-select/LED block. It is the driving and observing end of that sw[4:0] -> LED interface.
- It walks all 32 switch vectors, waits a settle interval, samples the returned LED, and compares it against an internal gate-function model.
- It reports mismatch count, first failing vector and pass/fail.
- It sits on the board-level test path in place of the physical switches and the human reading the LED.

Parameters:
- SETTLE_CYCLES, 4, cycles sw_out is held before LED is sampled; legal range is 3 or more (covers the 2-flop synchroniser).
- ERR_W, 6, width of the saturating mismatch counter.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- led_in  in  1  LED output returned from the block under test; asynchronous to clk, synchronised internally.
- sw_out  out  5  switch vector to the block under test: [4:2] select, [1] b, [0] a.
- busy  out  1  high while in DRIVE or CHECK.
- done  out  1  level, high in DONE until the next start or reset.
- pass  out  1  done AND err_count==0.
- err_count  out  ERR_W  number of mismatching vectors; saturates at all-ones.
- first_fail_valid  out  1  set on the first mismatch of a run.
- first_fail_vec  out  5  sw_out value of the first mismatch; 0 when first_fail_valid is 0.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; sw_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, vector counter=0, settle counter=0, both synchroniser flops=0.
  - Reset mid-run aborts immediately with no partial result retained.
- Synchroniser: led_in passes through 2 flops; only the second flop (led_s) is used.
- Expected model, with sel=sw_out[4:2], a=sw_out[0], b=sw_out[1]:
  - sel 0: ~(a&b)
  - sel 1: a&b
  - sel 2: ~(a|b)
  - sel 3: a|b
  - sel 4: a^b
  - sel 5: ~(a^b)
  - sel 6: a
  - sel 7: ~a
- State machine, IDLE/DRIVE/CHECK/DONE:
  - IDLE: outputs idle. start=1 -> DRIVE. On that transition: vector=0, sw_out=0, settle=0, err_count=0, first_fail_valid=0, first_fail_vec=0, done=0.
  - DRIVE: sw_out=vector, registered. settle increments each cycle. When settle==SETTLE_CYCLES-1 -> CHECK. DRIVE lasts exactly SETTLE_CYCLES cycles.
  - CHECK (1 cycle): compare led_s against expected(sw_out).
    - On mismatch: err_count increments, saturating. If first_fail_valid==0, latch first_fail_vec=sw_out and set first_fail_valid.
    - If vector==31 -> DONE, with sw_out=0 on entry.
    - Otherwise vector+1, settle=0 -> DRIVE.
  - DONE: done=1 and results held. start=1 -> same restart as from IDLE.
- Run length: start sampled at edge N -> done first high after edge N + 32*(SETTLE_CYCLES+1). That is 160 cycles at default.
- sw_out holds stable across all DRIVE and CHECK cycles of one vector and changes only on the CHECK->DRIVE edge.
- start while busy: ignored, with no restart and no counter disturbance.
- start held high continuously: one run, then an immediate restart from DONE on the next cycle.
- err_count saturation: at 2^ERR_W-1 it holds. With default width, the maximum of 32 never saturates.

Test Plan:
- Golden combinational model wired led_in=f(sw_out), start pulse at cycle 10 -> done rises 160 cycles later; pass=1, err_count=0, first_fail_valid=0; sw_out visits 0..31 in order, each held 5 cycles.
- led_in stuck 0 -> err_count=16, first_fail_vec=5'b00000 (nand, a=b=0), pass=0.
- led_in stuck 1 -> err_count=16, first_fail_vec=5'b00011, pass=0.
- Model with xor/xnor swapped -> err_count=8, first_fail_vec=5'b10000; fully inverted model -> err_count=32.
- Golden model, start re-pulsed at cycle 40 mid-run -> ignored; done at 160 after the original start, pass=1. Then start in DONE -> done=0, and the new run completes with pass=1.
- rst_n low for 3 cycles mid-run (vector 12) -> all outputs 0 asynchronously, state IDLE; a later start gives a full clean run with pass=1.
